routing_config_writer: RTL and testbench
========================================

ROUTING_CONFIG_WRITER -- requirements
Module: routing_config_writer

Interface
- REQ-001: Parameter DATA_W, default 32, width of routing command word and Avalon data bus.
- REQ-002: Parameter FIFO_DEPTH, default 4, command buffer depth in words (power of 2, >=2).
- REQ-003: Parameter VERIFY, default 1: 1 = read back and compare after every write; 0 = write only.
- REQ-004: clk  input  1  single clock; all logic rising-edge.
- REQ-005: reset  input  1  asynchronous, active-high reset.
- REQ-006: cmd_valid  input  1  command word offered.
- REQ-007: cmd_ready  output  1  buffer can accept; transfer when cmd_valid && cmd_ready.
- REQ-008: cmd_data  input  DATA_W  routing word to write to the PIO slave.
- REQ-009: avm_address  output  2  Avalon-MM word address to slave; always 0.
- REQ-010: avm_chipselect  output  1  slave select.
- REQ-011: avm_write_n  output  1  active-low write strobe.
- REQ-012: avm_writedata  output  DATA_W  write data.
- REQ-013: avm_readdata  input  DATA_W  slave read data, valid combinationally while selected with write_n high.
- REQ-014: busy  output  1  high when state != IDLE or buffer non-empty.
- REQ-015: verify_err  output  1  sticky readback mismatch flag.
- REQ-016: err_clr  input  1  single-cycle clear of verify_err and err_count.
- REQ-017: err_count  output  8  saturating mismatch counter.
- REQ-018: last_written  output  DATA_W  most recent word written to slave.
- REQ-019: fifo_count  output  clog2(FIFO_DEPTH)+1  words buffered.

Function
- REQ-020: Buffer is a FIFO_DEPTH FIFO; cmd_ready = (fifo_count < FIFO_DEPTH), combinational from count only.
- REQ-021: Push and pop in the same cycle leave fifo_count unchanged; pop from empty never occurs.
- REQ-022: FSM states IDLE, WRITE, READ, CHECK; registered outputs only, no Avalon signal driven combinationally from cmd_*.
- REQ-023: IDLE: chipselect 0, write_n 1; if fifo_count != 0 next state WRITE, else stay.
- REQ-024: WRITE (exactly 1 cycle): chipselect 1, write_n 0, address 0, writedata = FIFO head; FIFO pops at cycle end; last_written loads head.
- REQ-025: WRITE next: READ if VERIFY=1; else WRITE if FIFO holds another word after pop, else IDLE.
- REQ-026: READ (exactly 1 cycle): chipselect 1, write_n 1, address 0; avm_readdata captured at the edge ending READ.
- REQ-027: CHECK (1 cycle): chipselect 0; if captured != last_written, set verify_err and increment err_count (saturate at 255); next WRITE if FIFO non-empty, else IDLE.
- REQ-028: Throughput: 1 word/cycle with VERIFY=0; 1 word/3 cycles with VERIFY=1.
- REQ-029: Latency: word accepted into empty FIFO in IDLE at edge N appears as write cycle N+1 to N+2.
- REQ-030: err_clr coincident with a mismatch in CHECK: mismatch wins, verify_err=1, err_count=1.
- REQ-031: avm_writedata holds last value outside WRITE; DATA_W bits written unmodified.

Reset
- REQ-032: On reset assertion, immediately: state IDLE, FIFO emptied, fifo_count 0, avm_chipselect 0, avm_write_n 1, avm_address 0, avm_writedata 0, last_written 0, verify_err 0, err_count 0, busy 0.
- REQ-033: Reset mid-WRITE or mid-READ aborts the transfer; buffered words are discarded, not resumed.
- REQ-034: cmd_ready is 1 after reset.

Verification
- REQ-035: VERIFY=1, push 0x0000_00A5, slave model echoes -> one write of 0xA5 at address 0, one read, verify_err 0, last_written 0xA5, busy drops after CHECK.
- REQ-036: Push 5 words back-to-back, no drain stall (FIFO_DEPTH=4) -> cmd_ready low when count 4, all 5 written in order, no word lost or duplicated.
- REQ-037: Slave model returns 0xDEAD_BEEF for written 0x1234_5678 -> verify_err 1, err_count 1; err_clr pulse -> both 0.
- REQ-038: 300 forced mismatches -> err_count saturates at 255; err_clr in same cycle as mismatch -> err_count 1.
- REQ-039: VERIFY=0, push 3 words in consecutive cycles -> 3 consecutive write cycles, chipselect never low between them.
- REQ-040: Assert reset during WRITE with 2 words buffered -> chipselect 0, write_n 1, fifo_count 0 asynchronously; no further writes after release until new push.

Source files
------------

// File: rtl/routing_config_writer.sv
`default_nettype none
// ============================================================================
// Module      : routing_config_writer
// Description : Buffers routing command words and writes each one to an
//               Avalon-MM PIO slave, with an optional readback check.
// Revision    : 1.0 - initial release
// ============================================================================
module routing_config_writer #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int VERIFY     = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [DATA_W-1:0]           cmd_data,
    output logic [1:0]                  avm_address,
    output logic                        avm_chipselect,
    output logic                        avm_write_n,
    output logic [DATA_W-1:0]           avm_writedata,
    input  logic [DATA_W-1:0]           avm_readdata,
    output logic                        busy,
    output logic                        verify_err,
    input  logic                        err_clr,
    output logic [7:0]                  err_count,
    output logic [DATA_W-1:0]           last_written,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int c_aw = $clog2(FIFO_DEPTH);
    localparam int c_cw = c_aw + 1;
    localparam logic [c_cw-1:0] c_depth   = c_cw'(FIFO_DEPTH);
    localparam logic [c_cw-1:0] c_cnt_one = c_cw'(1);
    localparam logic [c_aw-1:0] c_ptr_one = c_aw'(1);

    localparam logic [1:0] c_s_idle  = 2'd0;
    localparam logic [1:0] c_s_write = 2'd1;
    localparam logic [1:0] c_s_read  = 2'd2;
    localparam logic [1:0] c_s_check = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [c_aw-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [c_cw-1:0]   count_q, count_d;
    logic              cs_q, cs_d, wn_q, wn_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, last_q, last_d, rdata_q, rdata_d;
    logic              verr_q, verr_d;
    logic [7:0]        ecnt_q, ecnt_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

    logic              w_push, w_pop, w_mismatch;
    logic [DATA_W-1:0] w_head;

    assign cmd_ready  = (count_q < c_depth);
    assign w_push     = cmd_valid && cmd_ready;
    assign w_pop      = (state_q == c_s_write);
    assign w_mismatch = (state_q == c_s_check) && (rdata_q != last_q);
    // Head after this edge; when the only word is popping, the word being
    // pushed becomes the new head and is not yet in the array.
    assign w_head     = (w_pop && count_q == c_cnt_one) ? cmd_data : mem_q[rd_ptr_d];

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= cmd_data;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) wr_ptr_d = wr_ptr_q + c_ptr_one;
        if (w_pop)  rd_ptr_d = rd_ptr_q + c_ptr_one;
        if (w_push && !w_pop)      count_d = count_q + c_cnt_one;
        else if (!w_push && w_pop) count_d = count_q - c_cnt_one;
        last_d  = w_pop ? wdata_q : last_q;
        rdata_d = (state_q == c_s_read) ? avm_readdata : rdata_q;
        verr_d  = verr_q;
        ecnt_d  = ecnt_q;
        // A mismatch takes precedence over a simultaneous clear.
        if (w_mismatch) begin
            verr_d = 1'b1;
            ecnt_d = err_clr ? 8'd1 : ((ecnt_q == 8'hFF) ? 8'hFF : ecnt_q + 8'd1);
        end else if (err_clr) begin
            verr_d = 1'b0;
            ecnt_d = 8'd0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_s_idle:  if (count_q != '0) state_d = c_s_write;
            c_s_write: begin
                if (VERIFY != 0)         state_d = c_s_read;
                else if (count_d != '0)  state_d = c_s_write;
                else                     state_d = c_s_idle;
            end
            c_s_read:  state_d = c_s_check;
            c_s_check: state_d = (count_q != '0) ? c_s_write : c_s_idle;
            default:   state_d = c_s_idle;
        endcase
    end

    // Bus outputs are decoded from the next state so the flops line up with it.
    always_comb begin
        cs_d    = (state_d == c_s_write) || (state_d == c_s_read);
        wn_d    = (state_d != c_s_write);
        wdata_d = (state_d == c_s_write) ? w_head : wdata_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= c_s_idle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            cs_q     <= 1'b0;
            wn_q     <= 1'b1;
            wdata_q  <= '0;
            last_q   <= '0;
            rdata_q  <= '0;
            verr_q   <= 1'b0;
            ecnt_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            cs_q     <= cs_d;
            wn_q     <= wn_d;
            wdata_q  <= wdata_d;
            last_q   <= last_d;
            rdata_q  <= rdata_d;
            verr_q   <= verr_d;
            ecnt_q   <= ecnt_d;
        end
    end

    assign avm_address    = 2'b00;
    assign avm_chipselect = cs_q;
    assign avm_write_n    = wn_q;
    assign avm_writedata  = wdata_q;
    assign busy           = (state_q != c_s_idle) || (count_q != '0);
    assign verify_err     = verr_q;
    assign err_count      = ecnt_q;
    assign last_written   = last_q;
    assign fifo_count     = count_q;

endmodule
`default_nettype wire

// File: tb/tb_routing_config_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_routing_config_writer
// Description : Directed and randomized bench for routing_config_writer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_routing_config_writer;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b0;
    logic          v1 = 1'b0, v0 = 1'b0, clr1 = 1'b0, clr0 = 1'b0, corrupt = 1'b0;
    logic [DW-1:0] d1 = '0, d0 = '0, rd0 = '0, slave_q = '0;
    logic          rdy1, cs1, wn1, busy1, verr1, rdy0, cs0, wn0, busy0, verr0;
    logic [1:0]    addr1, addr0;
    logic [DW-1:0] wd1, last1, rd1, wd0, last0;
    logic [7:0]    ecnt1, ecnt0;
    logic [2:0]    fc1, fc0;

    routing_config_writer #(.DATA_W(DW), .FIFO_DEPTH(4), .VERIFY(1)) dut (
        .clk(clk), .reset(reset), .cmd_valid(v1), .cmd_ready(rdy1), .cmd_data(d1),
        .avm_address(addr1), .avm_chipselect(cs1), .avm_write_n(wn1),
        .avm_writedata(wd1), .avm_readdata(rd1), .busy(busy1), .verify_err(verr1),
        .err_clr(clr1), .err_count(ecnt1), .last_written(last1), .fifo_count(fc1));

    routing_config_writer #(.DATA_W(DW), .FIFO_DEPTH(4), .VERIFY(0)) dut0 (
        .clk(clk), .reset(reset), .cmd_valid(v0), .cmd_ready(rdy0), .cmd_data(d0),
        .avm_address(addr0), .avm_chipselect(cs0), .avm_write_n(wn0),
        .avm_writedata(wd0), .avm_readdata(rd0), .busy(busy0), .verify_err(verr0),
        .err_clr(clr0), .err_count(ecnt0), .last_written(last0), .fifo_count(fc0));

    // PIO slave: stores the written word, returns it (or a corrupt value) on read
    always @(posedge clk) if (cs1 && !wn1) slave_q <= wd1;
    assign rd1 = corrupt ? 32'hDEAD_BEEF : slave_q;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] acc1[$], obs1[$], acc0[$], obs0[$];
    int            wcyc0[$];
    logic          pend = 1'b0, mverr = 1'b0;
    int            mcnt = 0;

    // Reference: accepted words, observed writes, and error bookkeeping
    always @(negedge clk) begin
        if (reset) begin
            pend <= 1'b0; mcnt <= 0; mverr <= 1'b0;
        end else begin
            if (v1 && rdy1) acc1.push_back(d1);
            if (cs1 && !wn1) obs1.push_back(wd1);
            if (v0 && rdy0) acc0.push_back(d0);
            if (cs0 && !wn0) begin obs0.push_back(wd0); wcyc0.push_back(cyc); end
            if (pend) begin
                mverr <= 1'b1;
                mcnt  <= clr1 ? 1 : ((mcnt >= 255) ? 255 : mcnt + 1);
            end else if (clr1) begin
                mverr <= 1'b0; mcnt <= 0;
            end
            pend <= (cs1 && wn1 && obs1.size() > 0 && obs1.size() <= acc1.size())
                    ? (rd1 !== acc1[obs1.size()-1]) : 1'b0;
        end
    end

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic push1(input logic [DW-1:0] w);
        int n = 0;
        d1 = w; v1 = 1'b1;
        do begin @(negedge clk); n++; end while (!rdy1 && n < 100);
        if (!rdy1) chk("push1_timeout", rdy1, 1);
        @(posedge clk); #1 v1 = 1'b0;
    endtask

    task automatic push0(input logic [DW-1:0] w);
        int n = 0;
        d0 = w; v0 = 1'b1;
        do begin @(negedge clk); n++; end while (!rdy0 && n < 100);
        if (!rdy0) chk("push0_timeout", rdy0, 1);
        @(posedge clk); #1 v0 = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin @(negedge clk); n++; end while ((busy1 || busy0) && n < 3000);
        chk("idle_reached", {busy1, busy0}, 0);
        @(posedge clk); #1;
    endtask

    task automatic clear_q();
        acc1.delete(); obs1.delete(); acc0.delete(); obs0.delete(); wcyc0.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] w[5];
        logic [DW-1:0] x;
        int n;

        // Reset state
        #1 reset = 1'b1;
        #1;
        chk("rst_bus", {cs1, wn1, addr1}, {1'b0, 1'b1, 2'b00});
        chk("rst_wdata_last", {wd1, last1}, 64'd0);
        chk("rst_err_busy_fc", {verr1, ecnt1, busy1, fc1}, 0);
        chk("rst_ready", rdy1, 1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Single write with echoing slave: exact cycle-by-cycle timing
        push1(32'h0000_00A5);
        @(negedge clk); chk("lat_idle_cs", cs1, 0); chk("lat_fc", fc1, 1);
        @(negedge clk); chk("wr_strobe", {cs1, wn1, addr1}, {1'b1, 1'b0, 2'b00});
                        chk("wr_data", wd1, 32'hA5);
        @(negedge clk); chk("rd_strobe", {cs1, wn1, addr1}, {1'b1, 1'b1, 2'b00});
        @(negedge clk); chk("check_cs", cs1, 0); chk("check_busy", busy1, 1);
        @(negedge clk); chk("done_busy", busy1, 0); chk("echo_verr", verr1, 0);
                        chk("echo_last", last1, 32'hA5); chk("hold_wdata", wd1, 32'hA5);
        @(posedge clk); #1;
        clear_q();

        // Five back-to-back words into a four-deep buffer
        for (int i = 0; i < 5; i++) w[i] = $urandom;
        for (int i = 0; i < 5; i++) push1(w[i]);
        @(negedge clk); chk("full_count", fc1, 4); chk("full_ready", rdy1, 0);
        @(posedge clk); #1;
        wait_idle();
        chk("order_len", obs1.size(), 5);
        for (int i = 0; i < 5 && i < obs1.size(); i++) chk("order_word", obs1[i], w[i]);
        chk("order_verr", verr1, 0);
        clear_q();

        // Corrupt readback, then clear
        corrupt = 1'b1;
        push1(32'h1234_5678);
        wait_idle();
        corrupt = 1'b0;
        chk("mis_verr", verr1, 1); chk("mis_cnt", ecnt1, 1);
        clr1 = 1'b1; @(posedge clk); #1 clr1 = 1'b0;
        @(negedge clk); chk("clr_state", {verr1, ecnt1}, 0);
        @(posedge clk); #1;
        clear_q();

        // Saturation after 300 mismatches
        corrupt = 1'b1;
        for (int i = 0; i < 300; i++) begin
            x = $urandom;
            if (x == 32'hDEAD_BEEF) x = x ^ 32'h1;
            push1(x);
        end
        wait_idle();
        chk("sat_cnt", ecnt1, 255); chk("sat_verr", verr1, 1);
        clear_q();

        // Clear coincident with a mismatch: mismatch wins
        push1(32'h0BAD_F00D);
        n = 0;
        do begin @(negedge clk); n++; end while (!(cs1 && wn1) && n < 50);
        chk("coin_read_seen", cs1 && wn1, 1);
        @(posedge clk); #1 clr1 = 1'b1;
        @(posedge clk); #1 clr1 = 1'b0;
        wait_idle();
        corrupt = 1'b0;
        chk("coin_cnt", ecnt1, 1); chk("coin_verr", verr1, 1);
        clr1 = 1'b1; @(posedge clk); #1 clr1 = 1'b0;
        clear_q();

        // Write-only instance: three consecutive pushes give three adjacent writes
        for (int i = 0; i < 3; i++) w[i] = $urandom;
        for (int i = 0; i < 3; i++) push0(w[i]);
        wait_idle();
        chk("wo_len", obs0.size(), 3);
        for (int i = 0; i < 3 && i < obs0.size(); i++) chk("wo_word", obs0[i], w[i]);
        if (wcyc0.size() == 3) begin
            chk("wo_adjacent1", wcyc0[1] - wcyc0[0], 1);
            chk("wo_adjacent2", wcyc0[2] - wcyc0[1], 1);
        end
        clear_q();

        // Randomized traffic on both instances against the model
        for (int i = 0; i < 200; i++) begin
            v1 = 1'($urandom % 2); d1 = $urandom;
            v0 = 1'($urandom % 2); d0 = $urandom;
            corrupt = ($urandom % 4 == 0);
            clr1 = ($urandom % 16 == 0);
            @(posedge clk); #1;
        end
        v1 = 1'b0; v0 = 1'b0; clr1 = 1'b0; corrupt = 1'b0;
        wait_idle();
        chk("rnd1_len", obs1.size(), acc1.size());
        for (int i = 0; i < obs1.size() && i < acc1.size(); i++) chk("rnd1_word", obs1[i], acc1[i]);
        chk("rnd0_len", obs0.size(), acc0.size());
        for (int i = 0; i < obs0.size() && i < acc0.size(); i++) chk("rnd0_word", obs0[i], acc0[i]);
        chk("rnd_cnt", ecnt1, mcnt[7:0]); chk("rnd_verr", verr1, mverr);
        clr1 = 1'b1; @(posedge clk); #1 clr1 = 1'b0;
        clear_q();

        // Reset during a write with two words buffered
        for (int i = 0; i < 3; i++) push1($urandom);
        n = 0;
        do begin @(negedge clk); n++; end while (!(cs1 && !wn1 && fc1 == 2) && n < 30);
        chk("abort_setup", {cs1, wn1, fc1}, {1'b1, 1'b0, 3'd2});
        #1 reset = 1'b1;
        #1;
        chk("abort_bus", {cs1, wn1}, {1'b1 ^ 1'b1, 1'b1});
        chk("abort_fc_busy", {fc1, busy1}, 0);
        @(posedge clk); @(posedge clk); #1 reset = 1'b0;
        clear_q();
        repeat (10) @(negedge clk);
        chk("abort_no_writes", obs1.size(), 0);
        chk("abort_idle", {fc1, busy1, cs1}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
